prf_busy_table: RTL and testbench
=================================

Name: prf_busy_table

Overview:
- Per-physical-register busy/ready scoreboard between rename/dispatch and the issue queues (INT IQ0/IQ1, MEM IQ).
- Sets a register busy when rename allocates it as a destination.
- Clears it when the same writeback ports that update the physical register file report completion.
- Tells dispatch whether each source operand of a 2-wide dispatch bundle is ready at insertion into an issue queue.

Parameters:
- PRF_NUM, 64, number of physical registers; p0 is hardwired zero.
- PRF_WIDTH, 6, physical register index width (log2 PRF_NUM).

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- flush  input  1  pipeline flush (mispredict/exception recovery)
- alloc0_valid  input  1  rename slot 0 allocates a destination
- alloc0_prd  input  PRF_WIDTH  slot 0 destination physical register
- alloc1_valid  input  1  rename slot 1 allocates a destination
- alloc1_prd  input  PRF_WIDTH  slot 1 destination physical register
- disp0_rs1_addr  input  PRF_WIDTH  dispatch slot 0 source 1
- disp0_rs2_addr  input  PRF_WIDTH  dispatch slot 0 source 2
- disp1_rs1_addr  input  PRF_WIDTH  dispatch slot 1 source 1
- disp1_rs2_addr  input  PRF_WIDTH  dispatch slot 1 source 2
- writeback0_need_to_wb .. writeback3_need_to_wb  input  1 each  writeback port valid
- writeback0_prd .. writeback3_prd  input  PRF_WIDTH each  writeback destination
- disp0_rs1_ready  output  1  slot 0 source 1 ready
- disp0_rs2_ready  output  1  slot 0 source 2 ready
- disp1_rs1_ready  output  1  slot 1 source 1 ready
- disp1_rs2_ready  output  1  slot 1 source 2 ready
- busy_vec  output  PRF_NUM  registered busy bits (debug / free-list checks)

Behaviour:
- State: PRF_NUM-bit register busy[]; busy_vec = busy.
- Reset (reset_n=0 at posedge): busy = all 0.
  - Ready outputs are combinational; with busy = 0 they read 1 unless a same-cycle alloc0 hazard applies.
- Index 0 is never busy.
  - Allocations and writebacks to p0 are ignored.
  - Queries of p0 always return ready = 1.
- Next-state per register r, evaluated in priority order:
  1. flush = 1: busy[r] = 0 for all r; allocations in the flush cycle are dropped.
  2. Else, allocated this cycle (allocN_valid and allocN_prd == r, r != 0): busy[r] = 1.
     - Allocation wins over a same-cycle writeback to the same r. That writeback is stale and is dropped.
  3. Else, any writebackK_need_to_wb with writebackK_prd == r: busy[r] = 0.
  4. Else: hold.
- alloc0_prd == alloc1_prd with both valid is illegal (rename guarantees it); the result is still busy = 1.
- Ready, combinational, zero latency, evaluated against pre-update state:
  - base = !busy[addr] || addr == 0.
  - Plus same-cycle writeback bypass (see Optional Feature).
- Intra-bundle hazard:
  - disp1_rsX_ready is forced to 0 when alloc0_valid, alloc0_prd != 0 and disp1_rsX_addr == alloc0_prd.
  - This overrides bypass; a writeback to that register this cycle is stale.
- Slot 0 sources are never compared against alloc0 or alloc1.
- Slot 1 sources are never compared against alloc1.
- flush has no effect on same-cycle ready outputs; dispatch is squashed upstream.
- Writeback to a register that is not busy: no effect and no error.
- Multiple writeback ports naming the same r: cleared once.

Optional Feature:
- Macro: PRF_BUSY_WB_BYPASS_EN.
- Defined: a ready output is also 1 when any writebackK_need_to_wb is set with writebackK_prd == addr (K = 0..3) in the same cycle. The intra-bundle hazard still takes precedence.
- Undefined: ready reflects registered busy only. A source completing in cycle N reads ready from cycle N+1.

Test Plan:
- Reset, then query p5 and p0 on all four ports: all ready = 1, busy_vec = 0.
- alloc0 p12 in cycle 1; query p12 in cycle 2: ready = 0, busy_vec[12] = 1. writeback2 p12 in cycle 3: busy_vec[12] = 0 in cycle 4.
- p12 busy, writeback1 p12 and disp0_rs1 = p12 in the same cycle: ready = 1 with PRF_BUSY_WB_BYPASS_EN, ready = 0 without it; the next cycle reads 1 either way.
- alloc0 p20 and disp1_rs2 = p20 in the same cycle: disp1_rs2_ready = 0. Same pattern on disp0_rs2: disp0_rs2_ready = 1 (p20 not yet busy).
- p7 idle; alloc1 p7 and writeback0 p7 in the same cycle: busy_vec[7] = 1 in the next cycle.
- p3, p9, p40 busy; flush with alloc0 p41 in the same cycle: the next cycle busy_vec = 0 (p41 not set). alloc0 p0 and writeback p0: busy_vec[0] stays 0.

Source files
------------

// File: rtl/prf_busy_table.sv
// prf_busy_table
//   Per-physical-register busy scoreboard sitting between rename/dispatch and
//   the issue queues. Rename sets a register busy when it is allocated as a
//   destination; the writeback ports clear it on completion. Four
//   combinational ready outputs tell dispatch whether each source of a
//   2-wide bundle may be treated as available when it enters an issue queue.
//
//   Optional build macro: PRF_BUSY_WB_BYPASS_EN
//     defined   - a source being written back in the current cycle reads ready
//     undefined - ready reflects only the registered busy bits
//
//   p0 is the hardwired-zero register: it is never busy and always ready.
module prf_busy_table #(
    parameter int PRF_NUM   = 64,
    parameter int PRF_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 alloc0_valid,
    input  logic [PRF_WIDTH-1:0] alloc0_prd,
    input  logic                 alloc1_valid,
    input  logic [PRF_WIDTH-1:0] alloc1_prd,
    input  logic [PRF_WIDTH-1:0] disp0_rs1_addr,
    input  logic [PRF_WIDTH-1:0] disp0_rs2_addr,
    input  logic [PRF_WIDTH-1:0] disp1_rs1_addr,
    input  logic [PRF_WIDTH-1:0] disp1_rs2_addr,
    input  logic                 writeback0_need_to_wb,
    input  logic [PRF_WIDTH-1:0] writeback0_prd,
    input  logic                 writeback1_need_to_wb,
    input  logic [PRF_WIDTH-1:0] writeback1_prd,
    input  logic                 writeback2_need_to_wb,
    input  logic [PRF_WIDTH-1:0] writeback2_prd,
    input  logic                 writeback3_need_to_wb,
    input  logic [PRF_WIDTH-1:0] writeback3_prd,
    output logic                 disp0_rs1_ready,
    output logic                 disp0_rs2_ready,
    output logic                 disp1_rs1_ready,
    output logic                 disp1_rs2_ready,
    output logic [PRF_NUM-1:0]   busy_vec
);

    localparam int NUM_WB    = 4;
    localparam int NUM_QUERY = 4;

    logic [PRF_NUM-1:0]   busy_reg;
    logic [PRF_NUM-1:0]   busy_next;

    // Writeback ports gathered into arrays so per-register logic can loop.
    logic [NUM_WB-1:0]    wb_valid;
    logic [PRF_WIDTH-1:0] wb_prd [NUM_WB];

    assign wb_valid  = {writeback3_need_to_wb, writeback2_need_to_wb,
                        writeback1_need_to_wb, writeback0_need_to_wb};
    assign wb_prd[0] = writeback0_prd;
    assign wb_prd[1] = writeback1_prd;
    assign wb_prd[2] = writeback2_prd;
    assign wb_prd[3] = writeback3_prd;

    // Query ports: index 0/1 are dispatch slot 0, index 2/3 are slot 1.
    logic [PRF_WIDTH-1:0] q_addr  [NUM_QUERY];
    logic [NUM_QUERY-1:0] q_ready;

    assign q_addr[0] = disp0_rs1_addr;
    assign q_addr[1] = disp0_rs2_addr;
    assign q_addr[2] = disp1_rs1_addr;
    assign q_addr[3] = disp1_rs2_addr;

    genvar gi;

    // Per-register next-state: flush, then allocation, then writeback, else hold.
    generate
        for (gi = 0; gi < PRF_NUM; gi++) begin : g_reg
            localparam logic [PRF_WIDTH-1:0] IDX = PRF_WIDTH'(gi);
            if (gi == 0) begin : g_zero
                // p0 ignores allocation and writeback entirely.
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic alloc_hit;
                logic wb_hit;

                assign alloc_hit = (alloc0_valid && (alloc0_prd == IDX)) ||
                                   (alloc1_valid && (alloc1_prd == IDX));

                // Any writeback port naming this register clears it (once).
                always_comb begin
                    wb_hit = 1'b0;
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_valid[k] && (wb_prd[k] == IDX)) begin
                            wb_hit = 1'b1;
                        end
                    end
                end

                // A same-cycle writeback to a freshly allocated register belongs
                // to the previous owner, so allocation takes priority over it.
                always_comb begin
                    if (flush) begin
                        busy_next[gi] = 1'b0;
                    end else if (alloc_hit) begin
                        busy_next[gi] = 1'b1;
                    end else if (wb_hit) begin
                        busy_next[gi] = 1'b0;
                    end else begin
                        busy_next[gi] = busy_reg[gi];
                    end
                end
            end
        end
    endgenerate

    // Busy state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    // Ready evaluation for each dispatch source against pre-update state.
    generate
        for (gi = 0; gi < NUM_QUERY; gi++) begin : g_query
            localparam bit IS_SLOT1 = (gi >= 2);
            logic hazard;

            // Slot 1 must not read ready for a register that slot 0 of the same
            // bundle is allocating: the value it needs is not produced yet.
            if (IS_SLOT1) begin : g_hazard
                assign hazard = alloc0_valid && (alloc0_prd != '0) &&
                                (q_addr[gi] == alloc0_prd);
            end else begin : g_no_hazard
                assign hazard = 1'b0;
            end

            // Base readiness, optional writeback bypass, then hazard override.
            always_comb begin
                q_ready[gi] = !busy_reg[q_addr[gi]] || (q_addr[gi] == '0);
`ifdef PRF_BUSY_WB_BYPASS_EN
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k] && (wb_prd[k] == q_addr[gi])) begin
                        q_ready[gi] = 1'b1;
                    end
                end
`endif
                if (hazard) begin
                    q_ready[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign disp0_rs1_ready = q_ready[0];
    assign disp0_rs2_ready = q_ready[1];
    assign disp1_rs1_ready = q_ready[2];
    assign disp1_rs2_ready = q_ready[3];

endmodule

// File: tb/tb_prf_busy_table.sv
// tb_prf_busy_table
//   Scoreboard bench for prf_busy_table. Each cycle, inputs are driven just
//   after the rising edge, expected ready/busy values are queued, and the
//   queue is drained and compared at the falling edge. Directed scenarios are
//   followed by a randomised run checked against a behavioural model.
//   Honours PRF_BUSY_WB_BYPASS_EN the same way the design does.
module tb_prf_busy_table;

    localparam int PRF_NUM   = 64;
    localparam int PRF_WIDTH = 6;

`ifdef PRF_BUSY_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 flush;
    logic                 alloc0_valid;
    logic [PRF_WIDTH-1:0] alloc0_prd;
    logic                 alloc1_valid;
    logic [PRF_WIDTH-1:0] alloc1_prd;
    logic [PRF_WIDTH-1:0] disp0_rs1_addr;
    logic [PRF_WIDTH-1:0] disp0_rs2_addr;
    logic [PRF_WIDTH-1:0] disp1_rs1_addr;
    logic [PRF_WIDTH-1:0] disp1_rs2_addr;
    logic [3:0]           wb_need;
    logic [PRF_WIDTH-1:0] wb_prd [4];
    logic                 disp0_rs1_ready;
    logic                 disp0_rs2_ready;
    logic                 disp1_rs1_ready;
    logic                 disp1_rs2_ready;
    logic [PRF_NUM-1:0]   busy_vec;

    always #5 clk = ~clk;

    prf_busy_table #(
        .PRF_NUM   (PRF_NUM),
        .PRF_WIDTH (PRF_WIDTH)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .flush                 (flush),
        .alloc0_valid          (alloc0_valid),
        .alloc0_prd            (alloc0_prd),
        .alloc1_valid          (alloc1_valid),
        .alloc1_prd            (alloc1_prd),
        .disp0_rs1_addr        (disp0_rs1_addr),
        .disp0_rs2_addr        (disp0_rs2_addr),
        .disp1_rs1_addr        (disp1_rs1_addr),
        .disp1_rs2_addr        (disp1_rs2_addr),
        .writeback0_need_to_wb (wb_need[0]),
        .writeback0_prd        (wb_prd[0]),
        .writeback1_need_to_wb (wb_need[1]),
        .writeback1_prd        (wb_prd[1]),
        .writeback2_need_to_wb (wb_need[2]),
        .writeback2_prd        (wb_prd[2]),
        .writeback3_need_to_wb (wb_need[3]),
        .writeback3_prd        (wb_prd[3]),
        .disp0_rs1_ready       (disp0_rs1_ready),
        .disp0_rs2_ready       (disp0_rs2_ready),
        .disp1_rs1_ready       (disp1_rs1_ready),
        .disp1_rs2_ready       (disp1_rs2_ready),
        .busy_vec              (busy_vec)
    );

    // Observation selectors.
    localparam int S_R01  = 0;
    localparam int S_R02  = 1;
    localparam int S_R11  = 2;
    localparam int S_R12  = 3;
    localparam int S_BUSY = 4;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "";

    function automatic logic [63:0] bit64(input int i);
        return 64'd1 << i;
    endfunction

    function automatic void push(input int sel, input logic [63:0] v);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        e.tag = cur_tag;
        exp_q.push_back(e);
    endfunction

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_R01:   return {63'd0, disp0_rs1_ready};
            S_R02:   return {63'd0, disp0_rs2_ready};
            S_R11:   return {63'd0, disp1_rs1_ready};
            S_R12:   return {63'd0, disp1_rs2_ready};
            default: return busy_vec;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_R01:   return "disp0_rs1_ready";
            S_R02:   return "disp0_rs2_ready";
            S_R11:   return "disp1_rs1_ready";
            S_R12:   return "disp1_rs2_ready";
            default: return "busy_vec";
        endcase
    endfunction

    task automatic clear_inputs();
        reset_n        = 1'b1;
        flush          = 1'b0;
        alloc0_valid   = 1'b0;
        alloc0_prd     = '0;
        alloc1_valid   = 1'b0;
        alloc1_prd     = '0;
        disp0_rs1_addr = '0;
        disp0_rs2_addr = '0;
        disp1_rs1_addr = '0;
        disp1_rs2_addr = '0;
        wb_need        = '0;
        for (int k = 0; k < 4; k++) wb_prd[k] = '0;
    endtask

    // Reset clears state; p5/p0 queries read ready afterwards.
    task automatic test_reset();
        exp_t        e;
        logic [63:0] obs;
        for (int s = 0; s < 5; s++) begin
            clear_inputs();
            cur_tag = $sformatf("reset/%0d", s);
            case (s)
                0: reset_n = 1'b0;
                1: begin
                    disp0_rs1_addr = 6'd5; disp0_rs2_addr = 6'd0;
                    disp1_rs1_addr = 6'd5; disp1_rs2_addr = 6'd0;
                    push(S_R01, 1); push(S_R02, 1); push(S_R11, 1); push(S_R12, 1);
                    push(S_BUSY, 64'd0);
                end
                2: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd5;
                    alloc1_valid = 1'b1; alloc1_prd = 6'd6;
                end
                3: begin
                    reset_n = 1'b0;
                    alloc0_valid = 1'b1; alloc0_prd = 6'd7;
                    disp0_rs1_addr = 6'd5;
                    push(S_R01, 0);
                    push(S_BUSY, bit64(5) | bit64(6));
                end
                default: begin
                    disp0_rs1_addr = 6'd5; disp0_rs2_addr = 6'd6;
                    disp1_rs1_addr = 6'd7; disp1_rs2_addr = 6'd0;
                    push(S_R01, 1); push(S_R02, 1); push(S_R11, 1); push(S_R12, 1);
                    push(S_BUSY, 64'd0);
                end
            endcase
            @(negedge clk);
            $display("txn %s: busy_vec=%h rdy=%b%b%b%b", cur_tag, busy_vec,
                     disp0_rs1_ready, disp0_rs2_ready, disp1_rs1_ready, disp1_rs2_ready);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Allocate p12, observe busy, clear through writeback port 2.
    task automatic test_alloc_wb();
        exp_t        e;
        logic [63:0] obs;
        for (int s = 0; s < 4; s++) begin
            clear_inputs();
            cur_tag = $sformatf("alloc_wb/%0d", s);
            case (s)
                0: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd12;
                    push(S_BUSY, 64'd0);
                end
                1: begin
                    disp0_rs1_addr = 6'd12; disp0_rs2_addr = 6'd12;
                    disp1_rs1_addr = 6'd12; disp1_rs2_addr = 6'd12;
                    push(S_R01, 0); push(S_R02, 0); push(S_R11, 0); push(S_R12, 0);
                    push(S_BUSY, bit64(12));
                end
                2: begin
                    wb_need[2] = 1'b1; wb_prd[2] = 6'd12;
                    disp1_rs1_addr = 6'd12;
                    push(S_R11, {63'd0, BYP});
                    push(S_BUSY, bit64(12));
                end
                default: begin
                    disp0_rs1_addr = 6'd12; disp0_rs2_addr = 6'd12;
                    disp1_rs1_addr = 6'd12; disp1_rs2_addr = 6'd12;
                    push(S_R01, 1); push(S_R02, 1); push(S_R11, 1); push(S_R12, 1);
                    push(S_BUSY, 64'd0);
                end
            endcase
            @(negedge clk);
            $display("txn %s: busy_vec=%h rdy=%b%b%b%b", cur_tag, busy_vec,
                     disp0_rs1_ready, disp0_rs2_ready, disp1_rs1_ready, disp1_rs2_ready);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Same-cycle writeback bypass on slot 0 source 1.
    task automatic test_bypass();
        exp_t        e;
        logic [63:0] obs;
        for (int s = 0; s < 3; s++) begin
            clear_inputs();
            cur_tag = $sformatf("bypass/%0d", s);
            case (s)
                0: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd12;
                end
                1: begin
                    wb_need[1] = 1'b1; wb_prd[1] = 6'd12;
                    disp0_rs1_addr = 6'd12;
                    push(S_R01, {63'd0, BYP});
                    push(S_BUSY, bit64(12));
                end
                default: begin
                    disp0_rs1_addr = 6'd12;
                    push(S_R01, 1);
                    push(S_BUSY, 64'd0);
                end
            endcase
            @(negedge clk);
            $display("txn %s: busy_vec=%h rdy=%b%b%b%b", cur_tag, busy_vec,
                     disp0_rs1_ready, disp0_rs2_ready, disp1_rs1_ready, disp1_rs2_ready);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Intra-bundle hazard: slot 1 vs alloc0 only, and it overrides bypass.
    task automatic test_hazard();
        exp_t        e;
        logic [63:0] obs;
        for (int s = 0; s < 6; s++) begin
            clear_inputs();
            cur_tag = $sformatf("hazard/%0d", s);
            case (s)
                0: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd20;
                    alloc1_valid = 1'b1; alloc1_prd = 6'd21;
                    wb_need[0] = 1'b1; wb_prd[0] = 6'd20;
                    disp0_rs1_addr = 6'd21; disp0_rs2_addr = 6'd20;
                    disp1_rs1_addr = 6'd21; disp1_rs2_addr = 6'd20;
                    push(S_R01, 1); push(S_R02, 1); push(S_R11, 1); push(S_R12, 0);
                    push(S_BUSY, 64'd0);
                end
                1: begin
                    wb_need[0] = 1'b1; wb_prd[0] = 6'd20;
                    wb_need[3] = 1'b1; wb_prd[3] = 6'd21;
                    disp0_rs1_addr = 6'd21; disp1_rs1_addr = 6'd20;
                    push(S_R01, {63'd0, BYP}); push(S_R11, {63'd0, BYP});
                    push(S_BUSY, bit64(20) | bit64(21));
                end
                2: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd30;
                    push(S_BUSY, 64'd0);
                end
                3: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd30;
                    wb_need[1] = 1'b1; wb_prd[1] = 6'd30;
                    disp1_rs1_addr = 6'd30; disp0_rs1_addr = 6'd30;
                    push(S_R11, 0); push(S_R01, {63'd0, BYP});
                    push(S_BUSY, bit64(30));
                end
                4: begin
                    wb_need[2] = 1'b1; wb_prd[2] = 6'd30;
                    push(S_BUSY, bit64(30));
                end
                default: begin
                    push(S_BUSY, 64'd0);
                end
            endcase
            @(negedge clk);
            $display("txn %s: busy_vec=%h rdy=%b%b%b%b", cur_tag, busy_vec,
                     disp0_rs1_ready, disp0_rs2_ready, disp1_rs1_ready, disp1_rs2_ready);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Allocation beats a same-cycle stale writeback.
    task automatic test_alloc_wins();
        exp_t        e;
        logic [63:0] obs;
        for (int s = 0; s < 3; s++) begin
            clear_inputs();
            cur_tag = $sformatf("alloc_wins/%0d", s);
            case (s)
                0: begin
                    alloc1_valid = 1'b1; alloc1_prd = 6'd7;
                    wb_need[0] = 1'b1; wb_prd[0] = 6'd7;
                    push(S_BUSY, 64'd0);
                end
                1: begin
                    wb_need[0] = 1'b1; wb_prd[0] = 6'd7;
                    push(S_BUSY, bit64(7));
                end
                default: push(S_BUSY, 64'd0);
            endcase
            @(negedge clk);
            $display("txn %s: busy_vec=%h rdy=%b%b%b%b", cur_tag, busy_vec,
                     disp0_rs1_ready, disp0_rs2_ready, disp1_rs1_ready, disp1_rs2_ready);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Flush drops state and same-cycle allocs; p0 is inert; duplicate writebacks.
    task automatic test_flush();
        exp_t        e;
        logic [63:0] obs;
        for (int s = 0; s < 6; s++) begin
            clear_inputs();
            cur_tag = $sformatf("flush/%0d", s);
            case (s)
                0: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd3;
                    alloc1_valid = 1'b1; alloc1_prd = 6'd9;
                end
                1: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd40;
                    push(S_BUSY, bit64(3) | bit64(9));
                end
                2: begin
                    flush = 1'b1;
                    alloc0_valid = 1'b1; alloc0_prd = 6'd41;
                    disp0_rs1_addr = 6'd3; disp1_rs1_addr = 6'd40;
                    push(S_R01, 0); push(S_R11, 0);
                    push(S_BUSY, bit64(3) | bit64(9) | bit64(40));
                end
                3: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd0;
                    alloc1_valid = 1'b1; alloc1_prd = 6'd9;
                    wb_need[0] = 1'b1; wb_prd[0] = 6'd0;
                    disp0_rs1_addr = 6'd41;
                    push(S_R01, 1);
                    push(S_BUSY, 64'd0);
                end
                4: begin
                    alloc0_valid = 1'b1; alloc0_prd = 6'd0;
                    wb_need[0] = 1'b1; wb_prd[0] = 6'd9;
                    wb_need[3] = 1'b1; wb_prd[3] = 6'd9;
                    disp0_rs1_addr = 6'd0; disp1_rs1_addr = 6'd0;
                    push(S_R01, 1); push(S_R11, 1);
                    push(S_BUSY, bit64(9));
                end
                default: push(S_BUSY, 64'd0);
            endcase
            @(negedge clk);
            $display("txn %s: busy_vec=%h rdy=%b%b%b%b", cur_tag, busy_vec,
                     disp0_rs1_ready, disp0_rs2_ready, disp1_rs1_ready, disp1_rs2_ready);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Randomised traffic on a small register window against a behavioural model.
    logic [63:0] model_busy;

    function automatic logic model_ready(input logic [PRF_WIDTH-1:0] a, input bit slot1);
        logic r;
        r = !model_busy[a] || (a == 0);
        if (BYP) begin
            for (int k = 0; k < 4; k++)
                if (wb_need[k] && wb_prd[k] == a) r = 1'b1;
        end
        if (slot1 && alloc0_valid && alloc0_prd != 0 && a == alloc0_prd) r = 1'b0;
        return r;
    endfunction

    task automatic test_random();
        exp_t        e;
        logic [63:0] obs;
        logic [63:0] nb;
        bit          wb_any;
        model_busy = busy_vec;
        for (int s = 0; s < 400; s++) begin
            clear_inputs();
            cur_tag = $sformatf("random/%0d", s);
            flush          = ($urandom_range(0, 24) == 0);
            alloc0_valid   = 1'($urandom_range(0, 1));
            alloc0_prd     = 6'($urandom_range(0, 15));
            alloc1_valid   = 1'($urandom_range(0, 1));
            alloc1_prd     = 6'($urandom_range(0, 15));
            disp0_rs1_addr = 6'($urandom_range(0, 15));
            disp0_rs2_addr = 6'($urandom_range(0, 15));
            disp1_rs1_addr = 6'($urandom_range(0, 15));
            disp1_rs2_addr = 6'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                wb_need[k] = 1'($urandom_range(0, 1));
                wb_prd[k]  = 6'($urandom_range(0, 15));
            end
            push(S_R01, {63'd0, model_ready(disp0_rs1_addr, 1'b0)});
            push(S_R02, {63'd0, model_ready(disp0_rs2_addr, 1'b0)});
            push(S_R11, {63'd0, model_ready(disp1_rs1_addr, 1'b1)});
            push(S_R12, {63'd0, model_ready(disp1_rs2_addr, 1'b1)});
            push(S_BUSY, model_busy);
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s %s: got %h expected %h", e.tag, sel_name(e.sel), obs, e.exp);
                end
            end
            nb = model_busy;
            if (flush) begin
                nb = '0;
            end else begin
                for (int r = 1; r < 64; r++) begin
                    wb_any = 1'b0;
                    for (int k = 0; k < 4; k++)
                        if (wb_need[k] && wb_prd[k] == r) wb_any = 1'b1;
                    if ((alloc0_valid && alloc0_prd == r) || (alloc1_valid && alloc1_prd == r))
                        nb[r] = 1'b1;
                    else if (wb_any)
                        nb[r] = 1'b0;
                end
            end
            model_busy = nb;
            @(posedge clk); #1;
        end
        $display("txn random: %0d cycles done", 400);
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_alloc_wb();
        test_bypass();
        test_hazard();
        test_alloc_wins();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
